// File: rtl/isa_read_responder.sv
// isa_read_responder
// DDR-side responder for instruction-cache fills. A fill request (start
// address, length in instructions) is split into DDR read bursts of at most
// MAX_BURST_LEN beats. Each accepted DDR beat is returned to the cache one
// cycle later as instruction_to_cache, with a one-cycle rd_burst_data_valid
// strobe and a running rd_cnt_isa count.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   isa_read_req/addr/len    cache fill request (held until fill complete)
//   instruction_to_cache     latest delivered instruction (LSBs of DDR beat)
//   rd_cnt_isa               instructions delivered in current fill (sat 1023)
//   rd_burst_data_valid      one-cycle strobe per delivered instruction
//   ddr_rd_req/addr/len      DDR burst request, stable until ddr_rd_grant
//   ddr_rd_grant             controller accepted the burst
//   ddr_rd_data/data_valid   DDR read beats
//   ddr_rd_finish            DDR burst complete
//   rd_timeout               (ISA_RD_TIMEOUT_EN only) sticky watchdog flag
//
// Optional feature macro: ISA_RD_TIMEOUT_EN adds a watchdog that abandons a
// fill after TIMEOUT_CYCLES cycles without DDR progress.
module isa_read_responder #(
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int DDR_DATA_WIDTH = 64,
  parameter int ISA_WIDTH      = 30,
  parameter int MAX_BURST_LEN  = 64,
  parameter int ADDR_STEP      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      isa_read_req,
  input  logic [DDR_ADDR_WIDTH-1:0] isa_read_addr,
  input  logic [9:0]                isa_read_len,
  output logic [ISA_WIDTH-1:0]      instruction_to_cache,
  output logic [9:0]                rd_cnt_isa,
  output logic                      rd_burst_data_valid,
  output logic                      ddr_rd_req,
  output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr,
  output logic [9:0]                ddr_rd_len,
  input  logic                      ddr_rd_grant,
  input  logic [DDR_DATA_WIDTH-1:0] ddr_rd_data,
  input  logic                      ddr_rd_data_valid,
  input  logic                      ddr_rd_finish
`ifdef ISA_RD_TIMEOUT_EN
  ,
  output logic                      rd_timeout
`endif
);

  localparam logic [9:0] MAX_LEN = 10'(MAX_BURST_LEN);
  localparam logic [9:0] CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                    state;
  logic [DDR_ADDR_WIDTH-1:0] cur_addr;
  logic [9:0]                remaining;
  logic [9:0]                beat_cnt;
  logic                      abort;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + 10'd1;
  endfunction

  function automatic logic [9:0] burst_len_of(input logic [9:0] rem);
    return (rem > MAX_LEN) ? MAX_LEN : rem;
  endfunction

  // A beat counts only in DATA and only up to the granted burst length;
  // surplus beats from the controller are dropped silently.
  logic                      beat_ok;
  logic [9:0]                rem_next;
  logic [DDR_ADDR_WIDTH-1:0] addr_next;

  assign beat_ok   = (state == S_DATA) && ddr_rd_data_valid && (beat_cnt < ddr_rd_len);
  assign rem_next  = remaining - ddr_rd_len;
  // Address wraps modulo 2^DDR_ADDR_WIDTH by truncation.
  assign addr_next = cur_addr + DDR_ADDR_WIDTH'(ddr_rd_len) * DDR_ADDR_WIDTH'(ADDR_STEP);

`ifdef ISA_RD_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_active;
  logic            wd_fire;

  assign wd_active = (state == S_REQ) || (state == S_DATA);
  assign wd_fire   = wd_active && !ddr_rd_grant && !ddr_rd_data_valid &&
                     (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= S_IDLE;
      cur_addr             <= '0;
      remaining            <= '0;
      beat_cnt             <= '0;
      abort                <= 1'b0;
      instruction_to_cache <= '0;
      rd_cnt_isa           <= '0;
      rd_burst_data_valid  <= 1'b0;
      ddr_rd_req           <= 1'b0;
      ddr_rd_addr          <= '0;
      ddr_rd_len           <= '0;
`ifdef ISA_RD_TIMEOUT_EN
      rd_timeout           <= 1'b0;
      wd_cnt               <= '0;
`endif
    end else begin
      // Beat -> cache stage boundary: one cycle of latency.
      rd_burst_data_valid <= 1'b0;
      if (beat_ok) begin
        instruction_to_cache <= ddr_rd_data[ISA_WIDTH-1:0];
        rd_cnt_isa           <= sat_inc(rd_cnt_isa);
        rd_burst_data_valid  <= 1'b1;
        beat_cnt             <= beat_cnt + 10'd1;
      end

      // Request withdrawn mid-fill: finish the outstanding burst, then stop.
      if (((state == S_REQ) || (state == S_DATA)) && !isa_read_req)
        abort <= 1'b1;

      case (state)
        S_IDLE: begin
          if (isa_read_req) begin
            cur_addr   <= isa_read_addr;
            remaining  <= isa_read_len;
            rd_cnt_isa <= '0;
            abort      <= 1'b0;
`ifdef ISA_RD_TIMEOUT_EN
            rd_timeout <= 1'b0;
`endif
            if (isa_read_len == 10'd0) begin
              state <= S_DONE;
            end else begin
              state       <= S_REQ;
              ddr_rd_req  <= 1'b1;
              ddr_rd_addr <= isa_read_addr;
              ddr_rd_len  <= burst_len_of(isa_read_len);
            end
          end
        end
        S_REQ: begin
          if (ddr_rd_grant) begin
            ddr_rd_req <= 1'b0;
            beat_cnt   <= '0;
            state      <= S_DATA;
          end
        end
        S_DATA: begin
          if (ddr_rd_finish) begin
            remaining <= rem_next;
            cur_addr  <= addr_next;
            if (rem_next == 10'd0) begin
              state <= S_DONE;
            end else if (abort || !isa_read_req) begin
              state <= S_IDLE;
            end else begin
              state       <= S_REQ;
              ddr_rd_req  <= 1'b1;
              ddr_rd_addr <= addr_next;
              ddr_rd_len  <= burst_len_of(rem_next);
            end
          end
        end
        S_DONE: begin
          if (!isa_read_req)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

`ifdef ISA_RD_TIMEOUT_EN
      // Watchdog: any grant or returned beat counts as progress.
      if (!wd_active || ddr_rd_grant || ddr_rd_data_valid)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_fire) begin
        rd_timeout <= 1'b1;
        ddr_rd_req <= 1'b0;
        state      <= S_DONE;
        rd_cnt_isa <= isa_read_len;
        wd_cnt     <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_isa_read_responder.sv
module tb_isa_read_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        isa_read_req;
  logic [27:0] isa_read_addr;
  logic [9:0]  isa_read_len;
  logic [29:0] instruction_to_cache;
  logic [9:0]  rd_cnt_isa;
  logic        rd_burst_data_valid;
  logic        ddr_rd_req;
  logic [27:0] ddr_rd_addr;
  logic [9:0]  ddr_rd_len;
  logic        ddr_rd_grant;
  logic [63:0] ddr_rd_data;
  logic        ddr_rd_data_valid;
  logic        ddr_rd_finish;
`ifdef ISA_RD_TIMEOUT_EN
  logic        rd_timeout;
`endif

  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;

  typedef struct {
    logic [29:0] ins;
    logic [9:0]  cnt;
    longint      at;
  } beat_t;
  typedef struct {
    logic [27:0] addr;
    logic [9:0]  len;
  } burst_t;

  beat_t  exp_beats[$];
  burst_t exp_bursts[$];

  isa_read_responder dut (
    .clk                 (clk),
    .rst                 (rst),
    .isa_read_req        (isa_read_req),
    .isa_read_addr       (isa_read_addr),
    .isa_read_len        (isa_read_len),
    .instruction_to_cache(instruction_to_cache),
    .rd_cnt_isa          (rd_cnt_isa),
    .rd_burst_data_valid (rd_burst_data_valid),
    .ddr_rd_req          (ddr_rd_req),
    .ddr_rd_addr         (ddr_rd_addr),
    .ddr_rd_len          (ddr_rd_len),
    .ddr_rd_grant        (ddr_rd_grant),
    .ddr_rd_data         (ddr_rd_data),
    .ddr_rd_data_valid   (ddr_rd_data_valid),
    .ddr_rd_finish       (ddr_rd_finish)
`ifdef ISA_RD_TIMEOUT_EN
    ,
    .rd_timeout          (rd_timeout)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event missing (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares delivered strobes and new DDR bursts with the queues.
  logic   req_q = 1'b0;
  beat_t  be;
  burst_t bu;
  always @(negedge clk) begin
    if (rst && rd_burst_data_valid) begin
      if (exp_beats.size() == 0) begin
        fail_now("unexpected_strobe");
      end else begin
        be = exp_beats.pop_front();
        check("strobe_instruction", 64'(instruction_to_cache), 64'(be.ins));
        check("strobe_rd_cnt",      64'(rd_cnt_isa),           64'(be.cnt));
        check("strobe_latency",     64'(cyc),                  64'(be.at));
      end
    end
    if (rst && ddr_rd_req && !req_q) begin
      if (exp_bursts.size() == 0) begin
        fail_now("unexpected_burst");
      end else begin
        bu = exp_bursts.pop_front();
        check("burst_addr", 64'(ddr_rd_addr), 64'(bu.addr));
        check("burst_len",  64'(ddr_rd_len),  64'(bu.len));
      end
    end
    req_q = ddr_rd_req;
  end

  // Acts as cache and DDR controller for one fill. Beat k of the fill carries
  // instruction k in its low 30 bits (junk above), expected count k+1.
  task automatic do_fill(input logic [27:0] addr, input int len, input int gdly,
                         input int extra, input bit same_fin, input int drop_at,
                         input int exp_final);
    int rem, idx, blen, n;
    isa_read_addr = addr;
    isa_read_len  = 10'(len);
    isa_read_req  = 1'b1;
    rem = len;
    idx = 0;
    while (rem > 0) begin
      n = 0;
      while (!ddr_rd_req && n < 50) begin
        tick();
        n++;
      end
      if (!ddr_rd_req) begin
        fail_now("ddr_rd_req_wait");
        break;
      end
      blen = int'(ddr_rd_len);
      // Stray beats while waiting for grant must be ignored.
      for (int g = 0; g < gdly; g++) begin
        ddr_rd_data_valid = 1'b1;
        ddr_rd_data       = 64'hBAD0_BAD0_3FFF_FFFF;
        tick();
      end
      ddr_rd_data_valid = 1'b0;
      ddr_rd_grant      = 1'b1;
      tick();
      ddr_rd_grant = 1'b0;
      check("req_drop_after_grant", 64'(ddr_rd_req), 64'd0);
      for (int b = 0; b < blen + extra; b++) begin
        ddr_rd_data_valid = 1'b1;
        ddr_rd_finish     = same_fin && (b == blen + extra - 1);
        if (b < blen) begin
          ddr_rd_data = {32'hDEAD_BEEF, 2'b11, 30'(idx)};
          exp_beats.push_back('{ins: 30'(idx), cnt: 10'(idx + 1), at: cyc + 1});
          if (idx == drop_at) isa_read_req = 1'b0;
          idx++;
        end else begin
          ddr_rd_data = {32'h0, 2'b00, 30'(900 + b)};
        end
        tick();
      end
      ddr_rd_data_valid = 1'b0;
      if (!same_fin) begin
        ddr_rd_finish = 1'b1;
        tick();
      end
      ddr_rd_finish = 1'b0;
      rem -= blen;
      if (!isa_read_req) break;
    end
    tick();
    check("final_rd_cnt", 64'(rd_cnt_isa), 64'(exp_final));
    if (isa_read_req) begin
      // DONE must not re-accept while the request stays high.
      for (int h = 0; h < 4; h++) begin
        tick();
        check("done_no_rerequest", 64'(ddr_rd_req), 64'd0);
      end
      check("done_holds_cnt", 64'(rd_cnt_isa), 64'(exp_final));
      isa_read_req = 1'b0;
      tick();
    end else begin
      for (int h = 0; h < 3; h++) begin
        tick();
        check("idle_no_request", 64'(ddr_rd_req), 64'd0);
      end
    end
  endtask

  initial begin
    int n;
    rst               = 1'b0;
    isa_read_req      = 1'b0;
    isa_read_addr     = '0;
    isa_read_len      = '0;
    ddr_rd_grant      = 1'b0;
    ddr_rd_data       = '0;
    ddr_rd_data_valid = 1'b0;
    ddr_rd_finish     = 1'b0;
    tick();
    tick();
    check("reset_rd_cnt",      64'(rd_cnt_isa),           64'd0);
    check("reset_strobe",      64'(rd_burst_data_valid),  64'd0);
    check("reset_instruction", 64'(instruction_to_cache), 64'd0);
    check("reset_ddr_req",     64'(ddr_rd_req),           64'd0);
    check("reset_ddr_addr",    64'(ddr_rd_addr),          64'd0);
    check("reset_ddr_len",     64'(ddr_rd_len),           64'd0);
    rst = 1'b1;
    tick();

    // Beats while idle produce nothing.
    ddr_rd_data_valid = 1'b1;
    ddr_rd_data       = 64'h1234;
    tick();
    tick();
    ddr_rd_data_valid = 1'b0;

    // Single 16-beat burst, grant after 3 cycles.
    exp_bursts.push_back('{addr: 28'h0000100, len: 10'd16});
    do_fill(28'h0000100, 16, 3, 0, 1'b0, -1, 16);

    // Zero-length fill: no burst, count cleared.
    do_fill(28'h0000500, 0, 0, 0, 1'b0, -1, 0);

    // 128 instructions: two 64-beat bursts, finish with last beat.
    exp_bursts.push_back('{addr: 28'h0000000, len: 10'd64});
    exp_bursts.push_back('{addr: 28'h0000200, len: 10'd64});
    do_fill(28'h0000000, 128, 1, 0, 1'b1, -1, 128);

    // Controller returns 20 beats for a 16-beat burst.
    exp_bursts.push_back('{addr: 28'h0000300, len: 10'd16});
    do_fill(28'h0000300, 16, 0, 4, 1'b1, -1, 16);

    // Request dropped mid-burst: first burst drains, no second burst.
    exp_bursts.push_back('{addr: 28'h0001000, len: 10'd64});
    do_fill(28'h0001000, 128, 2, 0, 1'b0, 10, 64);

    // Address wraps at 2^28.
    exp_bursts.push_back('{addr: 28'hFFFFF00, len: 10'd64});
    exp_bursts.push_back('{addr: 28'h0000100, len: 10'd64});
    do_fill(28'hFFFFF00, 128, 0, 0, 1'b0, -1, 128);

    // Reset asserted after beat 5 of a 16-beat burst.
    exp_bursts.push_back('{addr: 28'h0000040, len: 10'd16});
    isa_read_addr = 28'h0000040;
    isa_read_len  = 10'd16;
    isa_read_req  = 1'b1;
    n = 0;
    while (!ddr_rd_req && n < 50) begin
      tick();
      n++;
    end
    if (!ddr_rd_req) fail_now("reset_test_req_wait");
    ddr_rd_grant = 1'b1;
    tick();
    ddr_rd_grant = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ddr_rd_data_valid = 1'b1;
      ddr_rd_data       = {32'h0, 2'b00, 30'(k)};
      exp_beats.push_back('{ins: 30'(k), cnt: 10'(k + 1), at: cyc + 1});
      tick();
    end
    ddr_rd_data_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("async_reset_rd_cnt",      64'(rd_cnt_isa),           64'd0);
    check("async_reset_instruction", 64'(instruction_to_cache), 64'd0);
    check("async_reset_ddr_req",     64'(ddr_rd_req),           64'd0);
    check("async_reset_ddr_addr",    64'(ddr_rd_addr),          64'd0);
    check("async_reset_ddr_len",     64'(ddr_rd_len),           64'd0);
    isa_read_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    // Fresh fill after reset starts counting from zero.
    exp_bursts.push_back('{addr: 28'h0000080, len: 10'd16});
    do_fill(28'h0000080, 16, 1, 0, 1'b0, -1, 16);

    repeat (5) tick();
    check("scoreboard_beats_drained",  64'(exp_beats.size()),  64'd0);
    check("scoreboard_bursts_drained", 64'(exp_bursts.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/isa_read_responder.md
Name: isa_read_responder

Overview:
DDR-side responder for instruction-cache fills. It accepts the cache's ISA read request (address and length) and splits it into native DDR read bursts. It returns each instruction to the cache with a running beat count and a data-valid strobe. It sits between ins_cache and the DDR controller read port, opposite the cache's ISA_read_req / instruction_to_cache / rd_cnt_isa handshake.

Parameters:
DDR_ADDR_WIDTH, 28, byte address width of the DDR port
DDR_DATA_WIDTH, 64, DDR read data width; one instruction per beat, in the LSBs
ISA_WIDTH, 30, instruction width; must be <= DDR_DATA_WIDTH
MAX_BURST_LEN, 64, maximum beats per DDR burst
ADDR_STEP, 8, byte address increment per beat
TIMEOUT_CYCLES, 1024, watchdog limit (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
isa_read_req  in  1  fill request from cache; held high until rd_cnt_isa >= isa_read_len
isa_read_addr  in  DDR_ADDR_WIDTH  fill start byte address; sampled on request acceptance
isa_read_len  in  10  fill length in instructions; sampled on request acceptance
instruction_to_cache  out  ISA_WIDTH  latest returned instruction
rd_cnt_isa  out  10  instructions delivered in the current fill
rd_burst_data_valid  out  1  one-cycle strobe per delivered instruction
ddr_rd_req  out  1  DDR burst request
ddr_rd_addr  out  DDR_ADDR_WIDTH  DDR burst start address
ddr_rd_len  out  10  DDR burst length in beats
ddr_rd_grant  in  1  controller accepted the burst
ddr_rd_data  in  DDR_DATA_WIDTH  DDR read data
ddr_rd_data_valid  in  1  DDR read beat valid
ddr_rd_finish  in  1  DDR burst complete (one cycle)

Behaviour:
- Reset: all outputs are 0, state is IDLE, and internal remaining/address counters are 0.
- States and transitions:
  - IDLE: when isa_read_req = 1, latch cur_addr = isa_read_addr and remaining = isa_read_len, and clear rd_cnt_isa. If isa_read_len = 0, go to DONE; otherwise go to REQ.
  - REQ: hold ddr_rd_req = 1, ddr_rd_addr = cur_addr, ddr_rd_len = min(remaining, MAX_BURST_LEN). Address and length are stable while the request is high. On ddr_rd_grant, drop ddr_rd_req the next cycle and go to DATA.
  - DATA: on each ddr_rd_data_valid, while the burst beat count is below ddr_rd_len, register the following on the next clock:
    - instruction_to_cache <= ddr_rd_data[ISA_WIDTH-1:0]
    - rd_cnt_isa <= rd_cnt_isa + 1
    - rd_burst_data_valid <= 1 for exactly one cycle
    Latency from DDR beat to cache strobe is 1 cycle. instruction_to_cache and rd_cnt_isa hold until the next beat.
  - On ddr_rd_finish in DATA:
    - remaining -= burst_len
    - cur_addr += burst_len * ADDR_STEP, modulo 2^DDR_ADDR_WIDTH, wrapping silently
    - if remaining > 0, go to REQ; otherwise go to DONE.
  - DONE: hold rd_cnt_isa and instruction_to_cache. When isa_read_req = 0, go to IDLE. rd_cnt_isa stays at its final value until the next acceptance.
- Boundary conditions:
  - Excess DDR beats beyond ddr_rd_len are dropped, with no strobe and no count change.
  - ddr_rd_data_valid outside DATA is ignored.
  - ddr_rd_finish arriving in the same cycle as the last valid beat: the beat is delivered and the transition happens together.
  - isa_read_req dropped mid-fill: the current DDR burst is drained (strobes still emitted), then the block goes to IDLE without issuing further bursts.
  - A new request during DONE is not accepted until isa_read_req has been low for at least one cycle.
  - rd_cnt_isa saturates at 1023.
  - Reset mid-burst returns everything to reset values immediately. The DDR side must be reset with the same rst.

Optional Feature:
Macro ISA_RD_TIMEOUT_EN.
- Defined: adds output rd_timeout (1 bit, sticky, cleared by reset or by the next request acceptance). A watchdog counts cycles in REQ or DATA without a grant or a valid beat. When it reaches TIMEOUT_CYCLES:
  - rd_timeout is set
  - ddr_rd_req is dropped
  - the state goes to DONE
  - rd_cnt_isa is forced to isa_read_len, so the cache exits its load state
- Not defined: no port, no counter, no watchdog; the block waits indefinitely for the DDR controller.

Test Plan:
- Request addr 0x000_0100, len 16, MAX_BURST_LEN 64, grant after 3 cycles, 16 beats with data = index:
  - one burst, ddr_rd_addr 0x100, ddr_rd_len 16
  - 16 strobes, each 1 cycle after its beat
  - rd_cnt_isa goes 1..16 and instruction_to_cache equals the beat index
  - state DONE until req drops, then IDLE
- Request len 128 from addr 0: two bursts, (addr 0x000, len 64) then (addr 0x200, len 64); rd_cnt_isa reaches 128 and continues across bursts without reset.
- Request len 0: no ddr_rd_req asserted, rd_cnt_isa = 0, state DONE in the cycle after acceptance.
- DDR returns 20 beats for a 16-beat burst: exactly 16 strobes, and rd_cnt_isa stops at 16.
- Reset pulled low at beat 5 of a 16-beat burst: all outputs 0 in the same cycle, state IDLE. A fresh request after release fills correctly from rd_cnt_isa = 0.
- With ISA_RD_TIMEOUT_EN and TIMEOUT_CYCLES = 32, grant withheld: rd_timeout = 1 after 32 cycles, ddr_rd_req = 0, rd_cnt_isa = isa_read_len, state DONE.
